// File: rtl/err_monitor_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : err_monitor_pkg
// Description : Shared state encoding, counter widths and saturating helper
//               for the error monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package err_monitor_pkg;

    typedef enum logic [1:0] {
        ST_MONITOR = 2'd0,
        ST_RESET   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam int WCNT_W = 8;
    localparam int RCNT_W = 8;

    // Returns val+1 unless val has already reached lim.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] lim);
        return (val >= lim) ? val : val + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/err_ch_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : err_ch_counter
// Description : One error channel: rising-edge detect, saturating total
//               counter and window counter saturating at ERR_NUM.
// Revision    : 1.0 - initial release
// ============================================================================
module err_ch_counter
    import err_monitor_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int ERR_NUM = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_err,
    input  logic              i_mask,
    input  logic              i_clr,
    input  logic              i_win_en,
    input  logic              i_win_rst,
    input  logic              i_win_tc,
    output logic [CNT_W-1:0]  o_tot_cnt,
    output logic [WCNT_W-1:0] o_win_cnt,
    output logic              o_at_lim
);

    localparam logic [31:0] C_TOT_MAX = {32{1'b1}} >> (32 - CNT_W);

    logic              r_err_d1;
    logic              r_err_d2;
    logic [CNT_W-1:0]  r_tot;
    logic [WCNT_W-1:0] r_win;
    logic              w_evt;

    assign w_evt = r_err_d1 & ~r_err_d2 & ~i_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_d1 <= 1'b0;
            r_err_d2 <= 1'b0;
            r_tot    <= '0;
            r_win    <= '0;
        end else begin
            r_err_d1 <= i_err;
            r_err_d2 <= r_err_d1;

            if (i_clr)
                r_tot <= '0;
            else if (w_evt)
                r_tot <= CNT_W'(sat_inc(32'(r_tot), C_TOT_MAX));

            // A window rollover restarts the count, keeping a coincident event.
            if (i_clr || i_win_rst)
                r_win <= '0;
            else if (i_win_tc)
                r_win <= (w_evt && i_win_en) ? WCNT_W'(1) : '0;
            else if (w_evt && i_win_en)
                r_win <= WCNT_W'(sat_inc(32'(r_win), 32'(ERR_NUM)));
        end
    end

    assign o_tot_cnt = r_tot;
    assign o_win_cnt = r_win;
    assign o_at_lim  = (r_win == WCNT_W'(ERR_NUM));

endmodule
`default_nettype wire

// File: rtl/err_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : err_monitor
// Description : Multi-channel error monitor issuing a receiver reset pulse
//               when any channel's windowed error count reaches ERR_NUM.
// Revision    : 1.0 - initial release
// ============================================================================
module err_monitor
    import err_monitor_pkg::*;
#(
    parameter int CH_NUM  = 3,
    parameter int CNT_W   = 16,
    parameter int ERR_NUM = 5,
    parameter int WIN_LEN = 0,
    parameter int RST_LEN = 16,
    parameter int HOLDOFF = 100
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic [CH_NUM-1:0]       iERR,
    input  logic [CH_NUM-1:0]       iMASK,
    input  logic                    iCLR,
    output logic [CH_NUM*CNT_W-1:0] oERR_CNT,
    output logic                    oRST_RECEIVER,
    output logic [RCNT_W-1:0]       oRST_CNT,
    output logic [CH_NUM-1:0]       oTRIG_CH,
    output logic                    oBUSY
);

    localparam int   C_TMR_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int   C_TMR_LAST = (WIN_LEN > 0) ? WIN_LEN - 1 : 0;
    localparam int   C_PH_MAX   = (RST_LEN > HOLDOFF) ? RST_LEN : HOLDOFF;
    localparam int   C_PH_W     = (C_PH_MAX > 1) ? $clog2(C_PH_MAX) : 1;
    localparam int   C_RST_LAST = RST_LEN - 1;
    localparam int   C_HO_LAST  = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
    localparam logic C_WIN_ON   = (WIN_LEN != 0);

    state_t              r_state;
    logic [C_PH_W-1:0]   r_phase;
    logic [C_TMR_W-1:0]  r_win_tmr;
    logic                r_rst_rx;
    logic                r_busy;
    logic [RCNT_W-1:0]   r_rst_cnt;
    logic [CH_NUM-1:0]   r_trig;

    logic [CH_NUM-1:0]   w_at_lim;
    logic                w_in_mon;
    logic                w_trig;
    logic                w_win_tc;

    assign w_in_mon = (r_state == ST_MONITOR);
    assign w_trig   = w_in_mon && (|w_at_lim);
    assign w_win_tc = w_in_mon && C_WIN_ON && (r_win_tmr == C_TMR_W'(C_TMR_LAST));

    genvar g;
    generate
        for (g = 0; g < CH_NUM; g++) begin : g_ch
            logic [WCNT_W-1:0] w_win_cnt;

            err_ch_counter #(
                .CNT_W   (CNT_W),
                .ERR_NUM (ERR_NUM)
            ) u_ch (
                .clk       (iCLK),
                .rst_n     (iRST_N),
                .i_err     (iERR[g]),
                .i_mask    (iMASK[g]),
                .i_clr     (iCLR),
                .i_win_en  (w_in_mon),
                .i_win_rst (w_trig),
                .i_win_tc  (w_win_tc),
                .o_tot_cnt (oERR_CNT[g*CNT_W +: CNT_W]),
                .o_win_cnt (w_win_cnt),
                .o_at_lim  (w_at_lim[g])
            );
        end
    endgenerate

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state   <= ST_MONITOR;
            r_phase   <= '0;
            r_rst_rx  <= 1'b0;
            r_busy    <= 1'b0;
            r_rst_cnt <= '0;
            r_trig    <= '0;
        end else begin
            case (r_state)
                ST_MONITOR: begin
                    if (w_trig) begin
                        r_state  <= ST_RESET;
                        r_phase  <= '0;
                        r_rst_rx <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                ST_RESET: begin
                    if (r_phase == C_PH_W'(C_RST_LAST)) begin
                        r_phase  <= '0;
                        r_rst_rx <= 1'b0;
                        if (HOLDOFF == 0) begin
                            r_state <= ST_MONITOR;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_HOLDOFF;
                        end
                    end else begin
                        r_phase <= r_phase + C_PH_W'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (r_phase == C_PH_W'(C_HO_LAST)) begin
                        r_phase <= '0;
                        r_state <= ST_MONITOR;
                        r_busy  <= 1'b0;
                    end else begin
                        r_phase <= r_phase + C_PH_W'(1);
                    end
                end
                default: begin
                    r_state  <= ST_MONITOR;
                    r_phase  <= '0;
                    r_rst_rx <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase

            // Clear owns the trigger record and reset count but not the FSM.
            if (iCLR) begin
                r_trig    <= '0;
                r_rst_cnt <= '0;
            end else if (w_trig) begin
                r_trig    <= w_at_lim;
                r_rst_cnt <= RCNT_W'(sat_inc(32'(r_rst_cnt), 32'd255));
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            r_win_tmr <= '0;
        else if (iCLR || w_trig || w_win_tc)
            r_win_tmr <= '0;
        else if (w_in_mon && C_WIN_ON)
            r_win_tmr <= r_win_tmr + C_TMR_W'(1);
    end

    assign oRST_RECEIVER = r_rst_rx;
    assign oBUSY         = r_busy;
    assign oRST_CNT      = r_rst_cnt;
    assign oTRIG_CH      = r_trig;

endmodule
`default_nettype wire

// File: tb/tb_err_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_err_monitor
// Description : Directed bench for err_monitor with a cycle model and
//               hand-computed checkpoints.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_err_monitor;

    localparam int CH = 3;
    localparam int CW = 4;
    localparam int EN = 5;
    localparam int WL = 1000;
    localparam int RL = 4;
    localparam int HO = 10;

    logic            iCLK;
    logic            iRST_N;
    logic [CH-1:0]   iERR;
    logic [CH-1:0]   iMASK;
    logic            iCLR;
    logic [CH*CW-1:0] oERR_CNT;
    logic            oRST_RECEIVER;
    logic [7:0]      oRST_CNT;
    logic [CH-1:0]   oTRIG_CH;
    logic            oBUSY;

    int n_tests = 0;
    int n_fail  = 0;

    err_monitor #(
        .CH_NUM (CH), .CNT_W (CW), .ERR_NUM (EN),
        .WIN_LEN (WL), .RST_LEN (RL), .HOLDOFF (HO)
    ) dut (
        .iCLK (iCLK), .iRST_N (iRST_N), .iERR (iERR), .iMASK (iMASK),
        .iCLR (iCLR), .oERR_CNT (oERR_CNT), .oRST_RECEIVER (oRST_RECEIVER),
        .oRST_CNT (oRST_CNT), .oTRIG_CH (oTRIG_CH), .oBUSY (oBUSY)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: busy phase is a countdown of remaining busy cycles,
    // the receiver pulse being the first RL of them.
    int           m_tot [CH];
    int           m_win [CH];
    int           m_s1  [CH];
    int           m_s2  [CH];
    int           m_left;
    int           m_tmr;
    int           m_rcnt;
    logic [CH-1:0] m_trig;

    initial begin
        for (int c = 0; c < CH; c++) begin
            m_tot[c] = 0; m_win[c] = 0; m_s1[c] = 0; m_s2[c] = 0;
        end
        m_left = 0; m_tmr = 0; m_rcnt = 0; m_trig = '0;
        forever begin
            @(negedge iCLK);
            if (!iRST_N) begin
                for (int c = 0; c < CH; c++) begin
                    m_tot[c] = 0; m_win[c] = 0; m_s1[c] = 0; m_s2[c] = 0;
                end
                m_left = 0; m_tmr = 0; m_rcnt = 0; m_trig = '0;
            end
            for (int c = 0; c < CH; c++)
                chk($sformatf("model_tot_ch%0d", c), 32'(oERR_CNT[c*CW +: CW]), 32'(m_tot[c]));
            chk("model_rst_rx", 32'(oRST_RECEIVER), 32'(m_left > HO));
            chk("model_busy", 32'(oBUSY), 32'(m_left > 0));
            chk("model_rst_cnt", 32'(oRST_CNT), 32'(m_rcnt));
            chk("model_trig", 32'(oTRIG_CH), 32'(m_trig));
            if (iRST_N) begin
                logic          mon, trig, tc, ev;
                logic [CH-1:0] hit;
                mon = (m_left == 0);
                for (int c = 0; c < CH; c++) hit[c] = (m_win[c] == EN);
                trig = mon && (hit != '0);
                tc   = mon && (m_tmr == WL - 1);
                for (int c = 0; c < CH; c++) begin
                    ev = (m_s1[c] == 1) && (m_s2[c] == 0) && !iMASK[c];
                    if (iCLR) m_tot[c] = 0;
                    else if (ev && m_tot[c] < (1 << CW) - 1) m_tot[c]++;
                    if (iCLR || trig) m_win[c] = 0;
                    else if (tc) m_win[c] = (ev && mon) ? 1 : 0;
                    else if (ev && mon && m_win[c] < EN) m_win[c]++;
                    m_s2[c] = m_s1[c];
                    m_s1[c] = int'(iERR[c]);
                end
                if (iCLR) begin
                    m_trig = '0; m_rcnt = 0;
                end else if (trig) begin
                    m_trig = hit;
                    if (m_rcnt < 255) m_rcnt++;
                end
                if (iCLR || trig || tc) m_tmr = 0;
                else if (mon) m_tmr++;
                if (trig) m_left = RL + HO;
                else if (m_left > 0) m_left--;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic pulses(input logic [CH-1:0] m, input int n, input int gap);
        repeat (n) begin
            iERR = iERR | m;
            step(1);
            iERR = iERR & ~m;
            step(gap - 1);
        end
    endtask

    task automatic clear_all();
        iCLR = 1'b1;
        step(1);
        iCLR = 1'b0;
    endtask

    // Raises the final edge on m and profiles the following 30 cycles.
    task automatic measure(input logic [CH-1:0] m, output int first, output int highs, output int busy);
        first = -1; highs = 0; busy = 0;
        iERR = iERR | m;
        for (int i = 1; i <= 30; i++) begin
            @(posedge iCLK);
            #1;
            if (i == 1) iERR = iERR & ~m;
            if (oRST_RECEIVER) begin
                highs++;
                if (first < 0) first = i;
            end
            if (oBUSY) busy++;
        end
    endtask

    initial begin
        int first, highs, busy;
        bit seen;
        iRST_N = 1'b0; iERR = '0; iMASK = '0; iCLR = 1'b0;
        step(3);
        chk("reset_outputs", {oRST_RECEIVER, oBUSY, oRST_CNT, oTRIG_CH, oERR_CNT}, 32'd0);
        iRST_N = 1'b1;
        step(2);

        // Five pulses on ch1.
        pulses(3'b010, 4, 20);
        measure(3'b010, first, highs, busy);
        chk("c1_first_high", first, 3);
        chk("c1_pulse_width", highs, 4);
        chk("c1_busy_cycles", busy, 14);
        chk("c1_trig", oTRIG_CH, 3'b010);
        chk("c1_rst_cnt", oRST_CNT, 1);
        chk("c1_ch1_total", oERR_CNT[7:4], 5);

        // Four + four on ch0 across a window boundary.
        clear_all();
        pulses(3'b001, 4, 20);
        step(1000);
        pulses(3'b001, 4, 20);
        chk("c2_ch0_total", oERR_CNT[3:0], 8);
        chk("c2_rst_cnt", oRST_CNT, 0);

        // ch0 and ch2 reach five together.
        clear_all();
        pulses(3'b101, 4, 20);
        measure(3'b101, first, highs, busy);
        chk("c3_pulse_width", highs, 4);
        chk("c3_trig", oTRIG_CH, 3'b101);
        chk("c3_rst_cnt", oRST_CNT, 1);

        // Saturation on ch2, pulses falling in holdoff, then masked pulses.
        step(5);
        clear_all();
        pulses(3'b100, 20, 8);
        chk("c4_ch2_sat", oERR_CNT[11:8], 15);
        iMASK = 3'b100;
        pulses(3'b100, 3, 8);
        chk("c4_ch2_masked", oERR_CNT[11:8], 15);
        iMASK = 3'b000;
        step(20);

        // Clear coinciding with an event on ch1.
        clear_all();
        pulses(3'b010, 2, 6);
        chk("c5_ch1_pre", oERR_CNT[7:4], 2);
        iERR = 3'b010;
        step(1);
        iERR = 3'b000;
        iCLR = 1'b1;
        step(1);
        iCLR = 1'b0;
        step(2);
        chk("c5_all_cnt", 32'(oERR_CNT), 0);
        chk("c5_rst_cnt", oRST_CNT, 0);
        chk("c5_trig", oTRIG_CH, 0);

        // Asynchronous reset in the second RESET cycle.
        pulses(3'b001, 4, 20);
        iERR = 3'b001;
        step(1);
        iERR = 3'b000;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (oRST_RECEIVER) seen = 1'b1;
            else step(1);
        end
        chk("c6_pulse_seen", 32'(seen), 1);
        step(1);
        chk("c6_second_cycle_high", oRST_RECEIVER, 1);
        #1 iRST_N = 1'b0;
        #1;
        chk("c6_rst_rx_drop", oRST_RECEIVER, 0);
        chk("c6_outputs_zero", {oBUSY, oRST_CNT, oTRIG_CH, oERR_CNT}, 0);
        step(2);
        iRST_N = 1'b1;
        step(3);
        chk("c6_after_release", {oRST_RECEIVER, oBUSY, oRST_CNT, oTRIG_CH, oERR_CNT}, 0);

        step(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/err_monitor.md
ERR_MONITOR -- requirements
Module: err_monitor

Interface
REQ-001 Parameter CH_NUM, default 3: number of monitored error channels, range 1..8.
REQ-002 Parameter CNT_W, default 16: width of each per-channel total error counter.
REQ-003 Parameter ERR_NUM, default 5: error count within one window that triggers a receiver reset, range 1..255.
REQ-004 Parameter WIN_LEN, default 0: window length in iCLK cycles; 0 disables windowing, so counts accumulate until the next reset.
REQ-005 Parameter RST_LEN, default 16: oRST_RECEIVER pulse width in cycles, minimum 1.
REQ-006 Parameter HOLDOFF, default 100: cycles after the reset pulse during which window counting is suspended; 0 allowed.
REQ-007 iCLK  in  1  single clock; all inputs are synchronous to it.
REQ-008 iRST_N  in  1  asynchronous, active-low reset.
REQ-009 iERR  in  CH_NUM  error level per channel; each rising edge is one error event.
REQ-010 iMASK  in  CH_NUM  1 = channel ignored entirely (no total count, no window count).
REQ-011 iCLR  in  1  synchronous clear of all counters, oTRIG_CH and oRST_CNT.
REQ-012 oERR_CNT  out  CH_NUM*CNT_W  saturating total count per channel; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-013 oRST_RECEIVER  out  1  active-high receiver reset pulse.
REQ-014 oRST_CNT  out  8  saturating count of reset pulses issued.
REQ-015 oTRIG_CH  out  CH_NUM  channels whose window count reached ERR_NUM at the last trigger.
REQ-016 oBUSY  out  1  high in RESET and HOLDOFF states.

Function
REQ-017 Edge detection: iERR shall be registered (r1), then delayed again (r2); event = r1 & ~r2 & ~iMASK.
- iERR low at edge k-1 and high at edge k -> counters update at edge k+1.
REQ-018 Total counter: increments by 1 per event in every state and saturates at 2^CNT_W-1; no wrap.
REQ-019 Window counter, width 8, one per channel: increments per event only in MONITOR; saturates at ERR_NUM.
REQ-020 Window timer: runs from 0 to WIN_LEN-1 only in MONITOR. At the terminal count it clears all window counters; an event in that same cycle leaves the count at 1.
REQ-021 FSM states: MONITOR, RESET, HOLDOFF.
- MONITOR -> RESET on the cycle after any window counter equals ERR_NUM.
- RESET lasts exactly RST_LEN cycles, with oRST_RECEIVER=1, then goes to HOLDOFF.
- HOLDOFF lasts HOLDOFF cycles, then returns to MONITOR; if HOLDOFF=0, RESET goes directly to MONITOR.
REQ-022 Trigger latency: an event at edge k+1 that makes the window count equal ERR_NUM raises oRST_RECEIVER from edge k+2.
REQ-023 On entry to RESET, the block shall:
- latch oTRIG_CH with every channel at ERR_NUM (simultaneous channels give one pulse and multiple bits);
- increment oRST_CNT, saturating at 255;
- clear all window counters and the window timer.
REQ-024 Events during RESET and HOLDOFF shall update totals only.
REQ-025 iCLR priority: in a cycle where iCLR coincides with an event, clear wins; all counters end at 0.
REQ-026 iCLR shall clear oERR_CNT, window counters, window timer, oRST_CNT and oTRIG_CH, and shall not alter the FSM state or an ongoing pulse.
REQ-027 Masking a channel mid-window shall freeze its counters; unmasking shall not create a spurious event unless r1 & ~r2 holds.

Reset
REQ-028 On iRST_N=0, asynchronously, all outputs are 0, the FSM is in MONITOR, and r1/r2/timers/counters are 0.
REQ-029 A reset asserted mid-pulse shall drop oRST_RECEIVER immediately; after release the FSM restarts in MONITOR.

Structure
REQ-030 Package err_monitor_pkg holds:
- FSM state encoding (MONITOR=0, RESET=1, HOLDOFF=2);
- WCNT_W=8 and RCNT_W=8 constants;
- a saturating-increment function.
REQ-031 Sub-module err_ch_counter, instantiated CH_NUM times via generate, contains edge detect, total counter and window counter; the top holds the FSM, window timer and reset-pulse logic.

Verification (CH_NUM=3, CNT_W=4, ERR_NUM=5, WIN_LEN=1000, RST_LEN=4, HOLDOFF=10)
REQ-032 Case: 5 pulses on ch1, 20 cycles apart.
- Required: oRST_RECEIVER high for exactly 4 cycles, starting 2 cycles after the 5th edge is sampled.
- Required: oTRIG_CH=3'b010, oRST_CNT=1, ch1 total=5, oBUSY high for 14 cycles.
REQ-033 Case: 4 pulses on ch0, wait 1000 cycles, then 4 more.
- Required: no reset; ch0 total=8.
REQ-034 Case: ch0 and ch2 each reach their 5th edge in the same cycle.
- Required: a single 4-cycle pulse, oTRIG_CH=3'b101, oRST_CNT=1.
REQ-035 Case: 20 pulses on ch2 with iMASK=3'b000, then 3 pulses with iMASK=3'b100.
- Required: ch2 total saturates at 15, and the masked pulses change nothing.
- Required: pulses arriving in HOLDOFF raise only the totals.
REQ-036 Case: iCLR asserted together with an edge on ch1.
- Required: all counts become 0.
REQ-037 Case: iRST_N asserted in the 2nd RESET cycle.
- Required: oRST_RECEIVER falls immediately, and all outputs are 0.
